// File: rtl/sc_detector_pkg.sv
// Shared types and defaults for the Schmidl-Cox frame detector.
// State encoding is visible on state_o, so the values are fixed.
package sc_detector_pkg;

   typedef enum logic [2:0] {
      SEARCH  = 3'd0,
      PEAK    = 3'd1,
      WAIT    = 3'd2,
      FORWARD = 3'd3,
      HOLDOFF = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      MODE_ZERO  = 2'd0,
      MODE_GATED = 2'd1,
      MODE_MSB   = 2'd2,
      MODE_LSB   = 2'd3
   } out_mode_e;

   localparam int unsigned DEF_SYNC_OFFSET   = 1;
   localparam int unsigned DEF_PACKET_LENGTH = 1;
   localparam int unsigned DEF_MIN_PLATEAU   = 0;
   localparam int unsigned DEF_HOLDOFF       = 0;

endpackage

// File: rtl/sc_frame_detector.sv
// Schmidl-Cox timing detector: hysteresis peak search with plateau check,
// then forwards one packet a fixed offset after the peak, then holds off.
module sc_frame_detector
   import sc_detector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned METRIC_WIDTH = 64,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic [METRIC_WIDTH-1:0] thr_hi,
   input  logic [METRIC_WIDTH-1:0] thr_lo,
   input  logic [CNT_WIDTH-1:0]    sync_offset,
   input  logic [CNT_WIDTH-1:0]    packet_length,
   input  logic [CNT_WIDTH-1:0]    min_plateau,
   input  logic [CNT_WIDTH-1:0]    holdoff,
   input  logic [1:0]              out_mode,
   input  logic [METRIC_WIDTH-1:0] m_tdata,
   input  logic                    m_tlast,
   input  logic                    m_tvalid,
   output logic                    m_tready,
   input  logic [DATA_WIDTH-1:0]   i_tdata,
   input  logic                    i_tlast,
   input  logic                    i_tvalid,
   output logic                    i_tready,
   output logic [DATA_WIDTH-1:0]   o_tdata,
   output logic                    o_tlast,
   output logic                    o_tvalid,
   input  logic                    o_tready,
   output logic [31:0]             det_count,
   output logic [31:0]             rej_count,
   output logic [2:0]              state_o
);

   state_e                  state, state_nxt;
   logic                    en;
   logic [CNT_WIDTH-1:0]    cnt, cnt_nxt;
   logic [CNT_WIDTH-1:0]    plat, plat_nxt;
   logic [CNT_WIDTH-1:0]    fwd, fwd_nxt;
   logic [CNT_WIDTH-1:0]    off_s, off_s_nxt;
   logic [CNT_WIDTH-1:0]    len_s, len_s_nxt;
   logic [CNT_WIDTH-1:0]    minp_s, minp_s_nxt;
   logic [CNT_WIDTH-1:0]    hold_s, hold_s_nxt;
   logic [METRIC_WIDTH-1:0] max_q, max_nxt;
   logic [31:0]             det_nxt, rej_nxt;

   logic                    active, both, emit, ready_c, beat;
   logic                    pkt_first, pkt, pkt_last;
   logic [CNT_WIDTH-1:0]    fwd_idx, off_eff, len_eff, cnt_dec;
   out_mode_e               mode;

   logic unused_ok;
   assign unused_ok = i_tlast;

   // Handshake: metric and sample streams always advance together
   assign active    = en & ~reset & ~clear;
   assign mode      = out_mode_e'(out_mode);
   assign both      = m_tvalid & i_tvalid;
   assign pkt_first = ((state == PEAK) && (cnt == '0) && (plat >= minp_s)) ||
                      ((state == WAIT) && (cnt == '0));
   assign pkt       = pkt_first || (state == FORWARD);
   assign fwd_idx   = pkt_first ? CNT_WIDTH'(1) : fwd;
   assign pkt_last  = pkt && (fwd_idx == len_s);
   assign emit      = (mode != MODE_GATED) | pkt;
   assign ready_c   = active & both & (o_tready | ~emit);
   assign i_tready  = ready_c;
   assign m_tready  = ready_c;
   assign o_tvalid  = active & both & emit;
   assign beat      = both & ready_c;
   assign state_o   = state;

   assign off_eff = (sync_offset == '0) ? CNT_WIDTH'(1) : sync_offset;
   assign len_eff = (packet_length == '0) ? CNT_WIDTH'(1) : packet_length;
   assign cnt_dec = (cnt == '0) ? cnt : cnt - CNT_WIDTH'(1);

   // Output mux
   always_comb begin
      o_tdata = '0;
      o_tlast = 1'b0;
      if (active) begin
         case (mode)
            MODE_ZERO: begin
               o_tdata = pkt ? i_tdata : '0;
               o_tlast = pkt_last;
            end
            MODE_GATED: begin
               o_tdata = i_tdata;
               o_tlast = pkt_last;
            end
            MODE_MSB: begin
               o_tdata = m_tdata[METRIC_WIDTH-1 -: DATA_WIDTH];
               o_tlast = m_tlast;
            end
            MODE_LSB: begin
               o_tdata = m_tdata[DATA_WIDTH-1:0];
               o_tlast = m_tlast;
            end
            default: ;
         endcase
      end
   end

   // Next-state logic; everything only moves on a beat
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      plat_nxt   = plat;
      fwd_nxt    = fwd;
      max_nxt    = max_q;
      off_s_nxt  = off_s;
      len_s_nxt  = len_s;
      minp_s_nxt = minp_s;
      hold_s_nxt = hold_s;
      det_nxt    = det_count;
      rej_nxt    = rej_count;
      if (beat) begin
         if (pkt) begin
            if (pkt_first) det_nxt = det_count + 32'd1;
            if (pkt_last) begin
               if (hold_s == '0) begin
                  state_nxt = SEARCH;
               end else begin
                  state_nxt = HOLDOFF;
                  cnt_nxt   = hold_s - CNT_WIDTH'(1);
               end
            end else begin
               state_nxt = FORWARD;
               fwd_nxt   = fwd_idx + CNT_WIDTH'(1);
            end
         end else begin
            case (state)
               SEARCH: begin
                  if (m_tdata > thr_hi) begin
                     state_nxt  = PEAK;
                     max_nxt    = m_tdata;
                     cnt_nxt    = off_eff - CNT_WIDTH'(1);
                     plat_nxt   = CNT_WIDTH'(1);
                     off_s_nxt  = off_eff;
                     len_s_nxt  = len_eff;
                     minp_s_nxt = min_plateau;
                     hold_s_nxt = holdoff;
                  end
               end
               PEAK: begin
                  if (m_tdata > thr_lo) begin
                     plat_nxt = (plat == {CNT_WIDTH{1'b1}}) ? plat : plat + CNT_WIDTH'(1);
                     // Ties move the peak later
                     if (m_tdata >= max_q) begin
                        max_nxt = m_tdata;
                        cnt_nxt = off_s - CNT_WIDTH'(1);
                     end else begin
                        cnt_nxt = cnt_dec;
                     end
                  end else if (plat < minp_s) begin
                     state_nxt = SEARCH;
                     rej_nxt   = rej_count + 32'd1;
                  end else begin
                     state_nxt = WAIT;
                     cnt_nxt   = cnt_dec;
                  end
               end
               WAIT: cnt_nxt = cnt_dec;
               HOLDOFF: begin
                  if (cnt == '0) state_nxt = SEARCH;
                  else           cnt_nxt   = cnt - CNT_WIDTH'(1);
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset | clear) begin
         en        <= 1'b0;
         state     <= SEARCH;
         cnt       <= '0;
         plat      <= '0;
         fwd       <= '0;
         max_q     <= '0;
         off_s     <= CNT_WIDTH'(DEF_SYNC_OFFSET);
         len_s     <= CNT_WIDTH'(DEF_PACKET_LENGTH);
         minp_s    <= CNT_WIDTH'(DEF_MIN_PLATEAU);
         hold_s    <= CNT_WIDTH'(DEF_HOLDOFF);
         det_count <= '0;
         rej_count <= '0;
      end else begin
         en        <= 1'b1;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         plat      <= plat_nxt;
         fwd       <= fwd_nxt;
         max_q     <= max_nxt;
         off_s     <= off_s_nxt;
         len_s     <= len_s_nxt;
         minp_s    <= minp_s_nxt;
         hold_s    <= hold_s_nxt;
         det_count <= det_nxt;
         rej_count <= rej_nxt;
      end
   end

endmodule

// File: doc/sc_frame_detector.md
Name: sc_frame_detector

Overview:
Parametrised successor to the Schmidl-Cox timing detector in rfnoc_block_schmidl_cox. It consumes the metric stream and the sample-aligned IQ stream in lockstep. It finds the metric peak using hysteresis thresholds and rejects plateaus that are too short. It then forwards a programmable-length packet starting a programmable offset after the peak, followed by a holdoff period. Sits between the metric pipeline and the FFT/OFDM demod path; status feeds RFNoC registers.

Parameters:
DATA_WIDTH, 32, sample width (sc16 IQ)
METRIC_WIDTH, 64, metric width; must be >= DATA_WIDTH
CNT_WIDTH, 16, width of offset/length/holdoff/plateau counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous active-high clear, same effect as reset
thr_hi  in  METRIC_WIDTH  enter threshold (metric > thr_hi)
thr_lo  in  METRIC_WIDTH  exit threshold (metric <= thr_lo ends peak); software keeps thr_lo <= thr_hi
sync_offset  in  CNT_WIDTH  beats from peak to first forwarded sample; 0 treated as 1
packet_length  in  CNT_WIDTH  forwarded samples per packet; 0 treated as 1
min_plateau  in  CNT_WIDTH  minimum beats above thr_lo for a valid detection
holdoff  in  CNT_WIDTH  beats ignored after a packet before searching again
out_mode  in  2  00 zero-fill, 01 gated, 10 metric MSBs, 11 metric LSBs
m_tdata/m_tlast/m_tvalid/m_tready  in/in/in/out  METRIC_WIDTH/1/1/1  metric stream
i_tdata/i_tlast/i_tvalid/i_tready  in/in/in/out  DATA_WIDTH/1/1/1  sample stream
o_tdata/o_tlast/o_tvalid/o_tready  out/out/out/in  DATA_WIDTH/1/1/1  output stream
det_count  out  32  accepted detections, wraps
rej_count  out  32  plateau rejections, wraps
state_o  out  3  current FSM state

Behaviour:
- Registered enable `en`: 0 during reset|clear, 1 from the cycle after. While en=0: i_tready=m_tready=o_tvalid=0, o_tdata=0, o_tlast=0.
- Reset values: state SEARCH; all counters, max register, det_count, rej_count = 0.
- emit (combinational):
  - modes 10/11: emit=1.
  - mode 00: emit=1.
  - mode 01: emit=1 only for packet samples.
- Handshake: both = m_tvalid & i_tvalid. i_tready = m_tready = en & both & (o_tready | ~emit). o_tvalid = en & both & emit. beat = both & i_tready. Streams never advance independently. i_tlast and m_tlast are ignored except in modes 10/11.
- Config shadowing: sync_offset, packet_length, min_plateau and holdoff are latched on SEARCH->PEAK. Thresholds are live.
- All transitions below occur only on a beat.
- SEARCH: if metric > thr_hi -> PEAK; max=metric; cnt=off-1; plat=1.
- PEAK: packet-sample test is evaluated first: if cnt==0 and plat>=min_plateau, this beat is the first packet sample -> FORWARD, fwd=1, det_count+1.
  - Else, if metric > thr_lo: plat++ (saturating). If metric >= max (ties move the peak later), max=metric and cnt=off-1; otherwise cnt-1 (floor at 0).
  - Else, if plat < min_plateau -> SEARCH, rej_count+1.
  - Else -> WAIT, cnt-1 (floor at 0).
- WAIT: if cnt==0, this beat is the first packet sample -> FORWARD, fwd=1, det_count+1. Otherwise cnt-1. The metric is ignored.
- First packet sample lands exactly sync_offset beats after the final peak beat.
- FORWARD: every beat is a packet sample. When fwd==len, o_tlast=1 and next state is HOLDOFF (or SEARCH if holdoff==0); otherwise fwd+1.
  - len=1: the first packet sample also carries tlast and leaves FORWARD.
- HOLDOFF: count holdoff beats, then -> SEARCH. The metric is ignored.
- Output data:
  - Mode 00: i_tdata on packet samples, else 0; o_tlast only on the last packet sample.
  - Mode 01: packet samples only, with tlast.
  - Mode 10: m_tdata[METRIC_WIDTH-1 -: DATA_WIDTH], tlast=m_tlast.
  - Mode 11: m_tdata[DATA_WIDTH-1:0], tlast=m_tlast.
- out_mode changes take effect on the next beat; changing it mid-packet is legal but yields a truncated packet.
- reset/clear mid-packet: packet aborted with no tlast; both status counters cleared.
- Comparisons are unsigned, full METRIC_WIDTH.

Decomposition:
- Package sc_detector_pkg:
  - state enum (SEARCH=0, PEAK=1, WAIT=2, FORWARD=3, HOLDOFF=4), 3 bits
  - out_mode enum
  - localparams for default register values
- Single module; the output mux stays inline; no sub-module required.

Test Plan:
- Config: thr_hi=1000, thr_lo=800, min_plateau=4, sync_offset=576, packet_length=8, holdoff=16, mode 01. Metric ramp 900,1100,1500,1200,900,500 at beats 10..15 -> peak at beat 12; 8 samples out at beats 588..595; tlast on 595; det_count=1.
- Same config, plateau of 3 beats above 800 -> no output; rej_count=1; state back to SEARCH.
- Mode 00, same stimulus -> o_tvalid on every beat; zeros outside beats 588..595; single tlast at 595.
- Random o_tready/i_tvalid/m_tvalid backpressure (50%) -> identical beat indices and packet contents versus the no-stall run; i_tready==m_tready at all times.
- Second peak during HOLDOFF (beats 596..611) -> ignored; peak at beat 620 -> new packet 576 beats later; det_count=2.
- reset pulse at beat 590 -> outputs 0 during reset, no tlast, counters 0, next detection works normally.
